// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, with front-end stall.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            RegWrite_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [6:0]      func7_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      RDaddr_o,
    output logic            busy_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    state_t              state;
    logic [5:0]          cnt;
    logic [2*XLEN-1:0]   acc, mul_nxt, div_nxt, prod;
    logic [XLEN-1:0]     opd, res, a_mag, b_mag, special, iter_res, quo, rem;
    logic [XLEN:0]       mul_sum, div_diff;
    logic [1:0]          f3;
    logic [4:0]          rd;
    logic                neg_q, neg_r;
    logic                start, launch, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    always_comb begin
        start    = RegWrite_i && ALUOp_i == 2'b10 && func7_i == 7'b0000001;
        launch   = rst_i && state == IDLE && start && !flush_i;
        a_sgn    = func3_i[2] ? !func3_i[0] : (func3_i[1:0] == 2'b01 || func3_i[1:0] == 2'b10);
        b_sgn    = func3_i[2] ? !func3_i[0] : func3_i[1:0] == 2'b01;
        a_neg    = a_sgn && RS1data_i[XLEN-1];
        b_neg    = b_sgn && RS2data_i[XLEN-1];
        a_mag    = a_neg ? -RS1data_i : RS1data_i;
        b_mag    = b_neg ? -RS2data_i : RS2data_i;
        div_zero = func3_i[2] && RS2data_i == '0;
        div_ovf  = func3_i[2] && !func3_i[0] && RS1data_i == MIN_INT && RS2data_i == '1;
        special  = div_zero ? (func3_i[1] ? RS1data_i : '1) : (func3_i[1] ? '0 : MIN_INT);
        // multiplier sits in the low half of acc and shifts out as the product shifts in
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        mul_nxt  = {mul_sum, acc[XLEN-1:1]};
        // partial remainder in the high half, dividend/quotient in the low half
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        div_nxt  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod     = neg_q ? -mul_nxt : mul_nxt;
        quo      = div_nxt[XLEN-1:0];
        rem      = div_nxt[2*XLEN-1:XLEN];
        iter_res = state == MUL ? (f3 == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                 : f3[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
        busy_o   = state == MUL || state == DIV;
        stall_o  = launch || (busy_o && !flush_i);
        done_o   = state == DONE && !flush_i;
        result_o = done_o ? res : '0;
        RDaddr_o = done_o ? rd : '0;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opd   <= '0;
            res   <= '0;
            f3    <= '0;
            rd    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (launch) begin
                    f3    <= func3_i[1:0];
                    rd    <= RDaddr_i;
                    cnt   <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    acc   <= {{XLEN{1'b0}}, func3_i[2] ? a_mag : b_mag};
                    opd   <= func3_i[2] ? b_mag : a_mag;
                    res   <= special;
                    state <= (div_zero || div_ovf) ? DONE : func3_i[2] ? DIV : MUL;
                end
                MUL, DIV: if (flush_i) begin
                    state <= IDLE;
                end else begin
                    acc <= state == MUL ? mul_nxt : div_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(XLEN-1)) begin
                        res   <= iter_res;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for ex_muldiv_unit checked against a cycle-level
// behavioural model (arithmetic reference plus op latency) on every falling edge.
module tb_ex_muldiv_unit;
    localparam logic [31:0] MIN = 32'h80000000;
    logic clk = 0, rst_n = 1, reg_write = 0, flush = 0;
    logic [1:0] alu_op = 0;
    logic [6:0] func7 = 0;
    logic [2:0] func3 = 0;
    logic [31:0] rs1 = 0, rs2 = 0;
    logic [4:0] rd_in = 0;
    logic stall, done, busy;
    logic [31:0] result;
    logic [4:0] rd_out;
    int vecs = 0, errs = 0;
    int m_left = 0;
    logic [31:0] m_res = 0;
    logic [4:0] m_rd = 0;

    typedef struct packed {logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; logic [5:0] lat;} vec_t;
    vec_t tbl [21] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 6'd33},
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6'd33},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd33},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6'd33},
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 6'd33},
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 6'd33},
        '{3'd5, 32'd100,      32'd7,        32'd14,       6'd33},
        '{3'd7, 32'd100,      32'd7,        32'd2,        6'd33},
        '{3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 6'd1},
        '{3'd7, 32'h00001234, 32'h00000000, 32'h00001234, 6'd1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 6'd1},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 6'd33},
        '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd33},
        '{3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 6'd33},
        '{3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 6'd33},
        '{3'd4, 32'h80000000, 32'h00000001, 32'h80000000, 6'd33},
        '{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 6'd1},
        '{3'd6, 32'h00000005, 32'h00000000, 32'h00000005, 6'd1},
        '{3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 6'd33},
        '{3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 6'd33}
    };

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .RegWrite_i(reg_write), .ALUOp_i(alu_op), .func7_i(func7),
        .func3_i(func3), .RS1data_i(rs1), .RS2data_i(rs2), .RDaddr_i(rd_in), .flush_i(flush),
        .stall_o(stall), .done_o(done), .result_o(result), .RDaddr_o(rd_out), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        p = 0;
        case (f)
            3'd0, 3'd3: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd4: return b == 0 ? 32'hFFFFFFFF : (a == MIN && b == 32'hFFFFFFFF) ? MIN : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: return b == 0 ? a : (a == MIN && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
        return f == 3'd0 ? p[31:0] : p[63:32];
    endfunction

    function automatic bit is_m();
        return reg_write && alu_op == 2'b10 && func7 == 7'h01;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: m_left counts cycles to the done cycle (1 = done now, 0 = idle)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_left <= 0;
        else if (m_left == 0) begin
            if (is_m() && !flush) begin
                m_res  <= ref_op(func3, rs1, rs2);
                m_rd   <= rd_in;
                m_left <= (func3[2] && (rs2 == 0 || (!func3[0] && rs1 == MIN && rs2 == 32'hFFFFFFFF))) ? 1 : 33;
            end
        end else m_left <= flush ? 0 : m_left - 1;
    end

    always @(negedge clk) begin
        bit ed, es;
        ed = rst_n && m_left == 1 && !flush;
        es = rst_n && !flush && (m_left >= 2 || (m_left == 0 && is_m()));
        chk("stall", {31'b0, stall}, {31'b0, es});
        chk("done", {31'b0, done}, {31'b0, ed});
        chk("busy", {31'b0, busy}, {31'b0, rst_n && m_left >= 2});
        chk("result", result, ed ? m_res : 32'h0);
        chk("rd", {27'b0, rd_out}, ed ? {27'b0, m_rd} : 32'h0);
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        reg_write = 1; alu_op = 2'b10; func7 = 7'h01; func3 = f; rs1 = a; rs2 = b; rd_in = d;
    endtask

    task automatic idle_in();
        reg_write = 0; alu_op = 0; func7 = 0; func3 = 0; rs1 = 0; rs2 = 0; rd_in = 0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        @(posedge clk); #1;
        drive(f, a, b, d);
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic wait_done(output int lat, output logic [31:0] r, output logic [4:0] d);
        lat = -1; r = 0; d = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; r = result; d = rd_out;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic count_done(input int n, output int k);
        k = 0;
        repeat (n) begin
            @(negedge clk);
            k += int'(done);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v, input logic [4:0] d);
        int lat;
        logic [31:0] r;
        logic [4:0] dr;
        issue(v.f, v.a, v.b, d);
        wait_done(lat, r, dr);
        chk($sformatf("v%0d_latency", i), lat, {26'b0, v.lat});
        chk($sformatf("v%0d_result", i), r, v.e);
        chk($sformatf("v%0d_rdaddr", i), {27'b0, dr}, {27'b0, d});
        chk($sformatf("v%0d_model", i), ref_op(v.f, v.a, v.b), v.e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #1 rst_n = 0;
        drive(3'd0, 32'd3, 32'd4, 5'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {31'b0, stall}, 0);
        chk("reset_done", {31'b0, done}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_result", result, 0);
        idle_in();
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 21; i++) run_vec(i, tbl[i], 5'(i + 5));
        // DONE must not relaunch while the retiring op is still presented
        @(posedge clk); #1;
        drive(3'd5, 32'h55, 32'h0, 5'd9);
        @(posedge clk); #1;
        @(negedge clk);
        chk("held_done", {31'b0, done}, 1);
        chk("held_result", result, 32'hFFFFFFFF);
        @(posedge clk); #1;
        idle_in();
        count_done(40, k);
        chk("held_relaunch", k, 0);
        // non-M instructions
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            reg_write = p != 2; alu_op = p == 1 ? 2'b00 : 2'b10; func7 = p == 0 ? 7'h00 : 7'h01;
            repeat (4) begin
                @(negedge clk);
                chk($sformatf("nonm%0d_stall", p), {31'b0, stall}, 0);
                chk($sformatf("nonm%0d_done", p), {31'b0, done}, 0);
            end
        end
        @(posedge clk); #1;
        idle_in();
        count_done(40, k);
        chk("nonm_done_count", k, 0);
        // flush at cycle 10 of a MUL
        issue(3'd0, 32'd7, 32'd3, 5'd12);
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(negedge clk);
        chk("flush_stall", {31'b0, stall}, 0);
        chk("flush_busy", {31'b0, busy}, 1);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("flush_idle", {31'b0, busy}, 0);
        count_done(40, k);
        chk("flush_done_count", k, 0);
        // flush together with start in IDLE
        @(posedge clk); #1;
        drive(3'd0, 32'd2, 32'd2, 5'd3);
        flush = 1;
        @(negedge clk);
        chk("flush_start_stall", {31'b0, stall}, 0);
        @(posedge clk); #1;
        flush = 0;
        idle_in();
        count_done(40, k);
        chk("flush_start_done_count", k, 0);
        // asynchronous reset at cycle 20 of a DIV, then a normal op
        issue(3'd4, 32'd1000, 32'd7, 5'd3);
        repeat (19) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("areset_stall", {31'b0, stall}, 0);
        chk("areset_busy", {31'b0, busy}, 0);
        chk("areset_done", {31'b0, done}, 0);
        chk("areset_result", result, 0);
        chk("areset_rd", {27'b0, rd_out}, 0);
        @(posedge clk); #1 rst_n = 1;
        run_vec(99, tbl[6], 5'd17);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
